// File: rtl/pipe_slice.sv
// pipe_slice: cascaded valid/ready register slices (pass-through, forward-registered or full skid)
module pipe_slice #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1,
    parameter int MODE  = 2,
    parameter int CW    = $clog2(2*DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_up_in,
    input  logic             ready_down_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    output logic             ready_up_out,
    output logic [CW-1:0]    occupancy
);
    // bit 0 is the stage's upstream ready, bit 1 its downstream valid
    typedef enum logic [1:0] {EMPTY = 2'b01, BUSY = 2'b11, FULL = 2'b10} state_t;

    if (WIDTH < 1 || DEPTH < 1 || MODE < 0 || MODE > 2) begin : g_bad
        $error("pipe_slice: illegal parameters WIDTH=%0d DEPTH=%0d MODE=%0d", WIDTH, DEPTH, MODE);
    end

    if (MODE == 0) begin : g_wire
        assign data_out       = data_in;
        assign valid_down_out = valid_up_in;
        assign ready_up_out   = ready_down_in;
        assign occupancy      = '0;
    end else begin : g_pipe
        logic [WIDTH-1:0] d [DEPTH+1];
        logic             v [DEPTH+1];
        logic             r [DEPTH+1];
        logic [1:0]       beats [DEPTH];
        logic [CW-1:0]    occ;
        assign d[0]           = data_in;
        assign v[0]           = valid_up_in;
        assign r[DEPTH]       = ready_down_in;
        assign data_out       = d[DEPTH];
        assign valid_down_out = v[DEPTH];
        assign ready_up_out   = r[0];
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            if (MODE == 1) begin : g_fwd
                logic             val;
                logic [WIDTH-1:0] dat;
                assign r[i]     = r[i+1] | ~val;
                assign v[i+1]   = val;
                assign d[i+1]   = dat;
                assign beats[i] = {1'b0, val};
                // whenever the stage can move, it takes whatever upstream offers (or empties)
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        val <= 1'b0;
                        dat <= '0;
                    end else begin
                        if (v[i] && r[i]) dat <= d[i];
                        if (r[i]) val <= v[i];
                    end
                end
            end else begin : g_skid
                state_t           state, nxt;
                logic [WIDTH-1:0] main_reg, skid_reg;
                logic             up, dn, ld_main, ld_skid, pop;
                assign up       = v[i] & state[0];
                assign dn       = state[1] & r[i+1];
                assign pop      = (state == FULL) & dn;
                assign r[i]     = state[0];
                assign v[i+1]   = state[1];
                assign d[i+1]   = main_reg;
                assign beats[i] = {~state[0], &state};
                // state register; ready and valid are its bits, so ready never sees ready_down_in
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) state <= EMPTY;
                    else state <= nxt;
                end
                // next state and register load strobes
                always_comb begin
                    nxt     = state;
                    ld_main = 1'b0;
                    ld_skid = 1'b0;
                    case (state)
                        EMPTY: if (up) begin
                            nxt     = BUSY;
                            ld_main = 1'b1;
                        end
                        BUSY: if (up && dn) ld_main = 1'b1;
                        else if (up) begin
                            nxt     = FULL;
                            ld_skid = 1'b1;
                        end else if (dn) nxt = EMPTY;
                        FULL: if (dn) nxt = BUSY;
                        default: nxt = EMPTY;
                    endcase
                end
                // main feeds downstream; skid catches the one beat accepted after a stall
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        main_reg <= '0;
                        skid_reg <= '0;
                    end else begin
                        if (ld_main) main_reg <= d[i];
                        else if (pop) main_reg <= skid_reg;
                        if (ld_skid) skid_reg <= d[i];
                    end
                end
            end
        end
        // total beats held across all stages
        always_comb begin
            occ = '0;
            for (int k = 0; k < DEPTH; k++) occ = occ + CW'(beats[k]);
        end
        assign occupancy = occ;
    end
endmodule
